multiplicator_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential multiplicator among N_REQ requesters. It accepts level requests with operands and grants one requester at a time. It latches that requester's operands, pulses the multiplicator start, and waits for completion or a timeout. It then returns the product to the owner with a one-cycle valid pulse. It sits between client blocks and a single sequential multiplicator instance.

---
 rtl/multiplicator_arbiter_pkg.sv | 15 +
 rtl/multiplicator_arbiter_round_robin_picker.sv | 35 +++
 rtl/multiplicator_arbiter.sv | 162 ++++++++++++++++
 tb/tb_multiplicator_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicator_arbiter_pkg.sv
// Shared types and default sizing for the multiplicator arbiter and its picker.
package multiplicator_arbiter_pkg;

  localparam int WIDTH_DEF          = 8;
  localparam int N_REQ_DEF          = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/multiplicator_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first active request at or after rr_ptr, wrapping.
module round_robin_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_req
);

  logic found_s;

  // scan from rr_ptr upward, wrapping, and keep the first hit
  always_comb begin
    found_s    = 1'b0;
    winner_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && req[(int'(rr_ptr) + k) % N_REQ]) begin
        found_s    = 1'b1;
        winner_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      winner = N_REQ'(1) << winner_idx;
    end else begin
      winner = '0;
    end
    any_req = found_s;
  end

endmodule

// File: rtl/multiplicator_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplicator among N_REQ clients,
// with a timeout that returns a flagged zero product if the multiplicator never answers.
module multiplicator_arbiter
  import multiplicator_arbiter_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] multiplicand_in,
  input  logic [N_REQ*WIDTH-1:0] multiplier_in,
  output logic [N_REQ-1:0]       grant_out,
  output logic [N_REQ-1:0]       result_valid_out,
  output logic [2*WIDTH-1:0]     product_out,
  output logic                   overflow_out,
  output logic                   timeout_out,
  output logic                   busy_out,
  output logic [WIDTH-1:0]       multiplicand_out,
  output logic [WIDTH-1:0]       multiplier_out,
  output logic                   start_out,
  input  logic                   mult_done_in,
  input  logic [2*WIDTH-1:0]     mult_product_in,
  input  logic                   mult_overflow_in
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t         state_r, state_next_s;
  logic [IDX_W-1:0]   rr_ptr_r, owner_r, next_ptr_s, winner_idx_s;
  logic [N_REQ-1:0]   winner_s, grant_r, valid_r;
  logic               any_req_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic               done_q_r, done_rise_s, timeout_hit_s;
  logic [WIDTH-1:0]   mcand_r, mplier_r;
  logic [2*WIDTH-1:0] product_r;
  logic               overflow_r, timeout_r;

  round_robin_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req        (req_in),
    .rr_ptr     (rr_ptr_r),
    .winner     (winner_s),
    .winner_idx (winner_idx_s),
    .any_req    (any_req_s)
  );

  // wait-phase event decode and pointer advance
  always_comb begin
    cnt_next_s    = cnt_r + CNT_W'(1);
    done_rise_s   = mult_done_in && !done_q_r;
    timeout_hit_s = (cnt_next_s == CNT_W'(TIMEOUT_CYCLES));
    if (winner_idx_s == IDX_W'(N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = winner_idx_s + IDX_W'(1);
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: state_next_s = WAIT;
      WAIT: begin
        if (done_rise_s || timeout_hit_s) begin
          state_next_s = RESPOND;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESPOND: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // datapath: grant/operand latch, wait counter, result capture
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      grant_r    <= '0;
      valid_r    <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      cnt_r      <= '0;
      done_q_r   <= 1'b0;
      product_r  <= '0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      grant_r <= '0;
      valid_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r  <= winner_s;
            mcand_r  <= multiplicand_in[int'(winner_idx_s)*WIDTH +: WIDTH];
            mplier_r <= multiplier_in[int'(winner_idx_s)*WIDTH +: WIDTH];
            owner_r  <= winner_idx_s;
            rr_ptr_r <= next_ptr_s;
          end
        end
        ISSUE: begin
          cnt_r    <= '0;
          // seed with the live level so a done still high from the last op is not an edge
          done_q_r <= mult_done_in;
        end
        WAIT: begin
          cnt_r    <= cnt_next_s;
          done_q_r <= mult_done_in;
          if (done_rise_s) begin
            valid_r    <= N_REQ'(1) << owner_r;
            product_r  <= mult_product_in;
            overflow_r <= mult_overflow_in;
            timeout_r  <= 1'b0;
          end else if (timeout_hit_s) begin
            valid_r    <= N_REQ'(1) << owner_r;
            product_r  <= '0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b1;
          end
        end
        RESPOND: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign grant_out        = grant_r;
  assign result_valid_out = valid_r;
  assign product_out      = product_r;
  assign overflow_out     = overflow_r;
  assign timeout_out      = timeout_r;
  assign multiplicand_out = mcand_r;
  assign multiplier_out   = mplier_r;
  assign start_out        = (state_r == ISSUE);
  assign busy_out         = (state_r != IDLE);

endmodule

// File: tb/tb_multiplicator_arbiter.sv
// Scoreboard bench for multiplicator_arbiter with a behavioural 9-cycle multiplicator model.
module tb_multiplicator_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int TO = 64;
  localparam int LAT = 9;
  localparam int MODE_NORM = 0;
  localparam int MODE_NEVER = 1;
  localparam int MODE_HOLD = 2;

  logic clock = 1'b0;
  logic reset_in;
  logic [N-1:0] req_in;
  logic [N*W-1:0] multiplicand_in, multiplier_in;
  logic [N-1:0] grant_out, result_valid_out;
  logic [2*W-1:0] product_out;
  logic overflow_out, timeout_out, busy_out, start_out;
  logic [W-1:0] multiplicand_out, multiplier_out;
  logic mult_done, mult_ovf;
  logic [2*W-1:0] mult_product;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  int mode;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int idx;
    logic [2*W-1:0] prod;
    logic ovf;
    logic to;
    int lat;
    int start_cyc;
  } sb_t;
  sb_t sb_q[$];
  int exp_grant_q[$];

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      multiplicand_in[i*W +: W] = a_arr[i];
      multiplier_in[i*W +: W]   = b_arr[i];
    end
  end

  multiplicator_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock            (clock),
    .reset_in         (reset_in),
    .req_in           (req_in),
    .multiplicand_in  (multiplicand_in),
    .multiplier_in    (multiplier_in),
    .grant_out        (grant_out),
    .result_valid_out (result_valid_out),
    .product_out      (product_out),
    .overflow_out     (overflow_out),
    .timeout_out      (timeout_out),
    .busy_out         (busy_out),
    .multiplicand_out (multiplicand_out),
    .multiplier_out   (multiplier_out),
    .start_out        (start_out),
    .mult_done_in     (mult_done),
    .mult_product_in  (mult_product),
    .mult_overflow_in (mult_ovf)
  );

  // Multiplicator model: done 9 edges after start; overflow flag = product bit 15.
  // HOLD keeps done high after completion and drops it 3 cycles into the next op.
  logic m_busy;
  logic [3:0] m_cnt;
  logic [2*W-1:0] m_a, m_b;
  always @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      m_busy <= 1'b0; m_cnt <= 4'd0; mult_done <= 1'b0;
      mult_product <= 16'd0; mult_ovf <= 1'b0; m_a <= 16'd0; m_b <= 16'd0;
    end else if (start_out) begin
      m_busy <= 1'b1; m_cnt <= 4'd0;
      m_a <= {8'd0, multiplicand_out}; m_b <= {8'd0, multiplier_out};
      if (mode != MODE_HOLD) mult_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 4'd1;
      if (mode == MODE_HOLD && m_cnt == 4'd2) mult_done <= 1'b0;
      if (m_cnt == 4'(LAT - 1)) begin
        m_busy <= 1'b0;
        if (mode != MODE_NEVER) begin
          mult_done <= 1'b1;
          mult_product <= m_a * m_b;
          mult_ovf <= (m_a * m_b) >= 16'd32768;
        end
      end
    end else if (mode != MODE_HOLD) begin
      mult_done <= 1'b0;
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_grant"}, 32'(grant_out), 32'd0);
    check_val({tag, "_valid"}, 32'(result_valid_out), 32'd0);
    check_val({tag, "_product"}, 32'(product_out), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow_out), 32'd0);
    check_val({tag, "_timeout"}, 32'(timeout_out), 32'd0);
    check_val({tag, "_busy"}, 32'(busy_out), 32'd0);
    check_val({tag, "_start"}, 32'(start_out), 32'd0);
    check_val({tag, "_mcand"}, 32'(multiplicand_out), 32'd0);
    check_val({tag, "_mplier"}, 32'(multiplier_out), 32'd0);
  endtask

  // Monitor: grants push expected results, result pulses pop and compare
  int g;
  sb_t e, r;
  logic [15:0] p;
  always @(negedge clock) begin
    if (!reset_in && grant_out != 4'd0) begin
      if (exp_grant_q.size() == 0) begin
        check_val("spurious_grant", 32'(grant_out), 32'd0);
      end else begin
        g = exp_grant_q.pop_front();
        check_val("grant", 32'(grant_out), 32'd1 << g);
        check_val("start_with_grant", 32'(start_out), 32'd1);
        check_val("mcand_latched", 32'(multiplicand_out), 32'(a_arr[g]));
        check_val("mplier_latched", 32'(multiplier_out), 32'(b_arr[g]));
        p = {8'd0, a_arr[g]} * {8'd0, b_arr[g]};
        e.idx = g;
        e.start_cyc = cyc;
        if (mode == MODE_NEVER) begin
          e.prod = 16'd0; e.ovf = 1'b0; e.to = 1'b1; e.lat = TO + 1;
        end else begin
          e.prod = p; e.ovf = p[15]; e.to = 1'b0; e.lat = LAT + 2;
        end
        sb_q.push_back(e);
      end
    end
    if (result_valid_out != 4'd0) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_valid", 32'(result_valid_out), 32'd0);
      end else begin
        r = sb_q.pop_front();
        check_val("valid_owner", 32'(result_valid_out), 32'd1 << r.idx);
        check_val("product", 32'(product_out), 32'(r.prod));
        check_val("overflow", 32'(overflow_out), 32'(r.ovf));
        check_val("timeout", 32'(timeout_out), 32'(r.to));
        check_val("latency", 32'(cyc - r.start_cyc), 32'(r.lat));
      end
    end
  end

  task automatic wait_grant(input int idx);
    int n = 0;
    while (grant_out[idx] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) check_val("grant_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || exp_grant_q.size() != 0 || busy_out) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check_val("drain_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_in = 1'b1;
    req_in = 4'd0;
    mode = MODE_NORM;
    for (int i = 0; i < N; i++) begin a_arr[i] = 8'd0; b_arr[i] = 8'd0; end
    repeat (3) @(negedge clock);
    check_zero("reset");

    // all four held from reset release: grants 0,1,2,3,0
    a_arr[0] = 8'd3;   b_arr[0] = 8'd7;
    a_arr[1] = 8'd200; b_arr[1] = 8'd100;
    a_arr[2] = 8'd13;  b_arr[2] = 8'd11;
    a_arr[3] = 8'd255; b_arr[3] = 8'd255;
    req_in = 4'hF;
    exp_grant_q = '{0, 1, 2, 3, 0};
    @(negedge clock);
    reset_in = 1'b0;
    n = 0;
    while (exp_grant_q.size() != 0 && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) check_val("rr_wait_expired", 32'd0, 32'd1);
    req_in = 4'd0;
    wait_drain();

    // single request, dropped during ISSUE; grant exactly one cycle after req
    a_arr[2] = 8'd13; b_arr[2] = 8'd11;
    exp_grant_q.push_back(2);
    req_in = 4'b0100;
    @(negedge clock);
    check_val("grant_1cyc", 32'(grant_out), 32'd4);
    check_val("busy_in_issue", 32'(busy_out), 32'd1);
    req_in = 4'd0;
    wait_drain();

    // timeout, then a normal op
    mode = MODE_NEVER;
    a_arr[0] = 8'd5; b_arr[0] = 8'd6;
    exp_grant_q.push_back(0);
    req_in = 4'b0001;
    wait_grant(0);
    req_in = 4'd0;
    wait_drain();
    mode = MODE_NORM;
    a_arr[3] = 8'd9; b_arr[3] = 8'd9;
    exp_grant_q.push_back(3);
    req_in = 4'b1000;
    wait_grant(3);
    req_in = 4'd0;
    wait_drain();

    // stale done: second op starts with done still high
    mode = MODE_HOLD;
    a_arr[1] = 8'd20; b_arr[1] = 8'd30;
    exp_grant_q.push_back(1);
    req_in = 4'b0010;
    wait_grant(1);
    req_in = 4'd0;
    wait_drain();
    a_arr[2] = 8'd100; b_arr[2] = 8'd3;
    exp_grant_q.push_back(2);
    req_in = 4'b0100;
    wait_grant(2);
    req_in = 4'd0;
    wait_drain();
    mode = MODE_NORM;
    repeat (2) @(negedge clock);

    // reset in WAIT: in-flight result discarded, rr_ptr back to 0
    a_arr[2] = 8'd50; b_arr[2] = 8'd2;
    exp_grant_q.push_back(2);
    req_in = 4'b0100;
    wait_grant(2);
    req_in = 4'd0;
    repeat (4) @(negedge clock);
    reset_in = 1'b1;
    #1;
    check_zero("midreset");
    sb_q.delete();
    exp_grant_q.delete();
    @(negedge clock);
    reset_in = 1'b0;
    a_arr[1] = 8'd7; b_arr[1] = 8'd6;
    a_arr[3] = 8'd2; b_arr[3] = 8'd50;
    exp_grant_q = '{1, 3};
    req_in = 4'b1010;
    wait_grant(1);
    req_in = 4'b1000;
    wait_grant(3);
    req_in = 4'd0;
    wait_drain();
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
